rgb2gray_frame_loader: RTL and testbench

Upstream feeder for the LBP engine. Accepts a raster RGB pixel stream and converts each pixel to 8-bit gray through a 2-stage pipeline. Writes the full 128x128 frame into the external gray SRAM, then asserts gray_ready and hands the SRAM read port to the LBP engine until it raises finish.

---
 rtl/gray_pkg.sv | 22 ++
 rtl/rgb2gray_pipe.sv | 56 +++++
 rtl/rgb2gray_frame_loader.sv | 112 +++++++++++
 tb/tb_rgb2gray_frame_loader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared constants and types for the RGB-to-gray frame loader.
// Coefficients are BT.601 luma weights scaled by 256.
package gray_pkg;

  localparam int IMG_W_D = 128;
  localparam int IMG_H_D = 128;
  localparam int AW_D    = 14;

  localparam logic [15:0] C_R = 16'd77;
  localparam logic [15:0] C_G = 16'd150;
  localparam logic [15:0] C_B = 16'd29;
  localparam logic [15:0] RND = 16'd128;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, READY} state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

endpackage

// File: rtl/rgb2gray_pipe.sv
// Two-stage RGB->gray converter; valid and write address travel with the data.
// Never stalls: one output beat per input beat, two edges later.
module rgb2gray_pipe
  import gray_pkg::*;
#(
  parameter int AW = AW_D
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  rgb_t          in_pix,
  input  logic [AW-1:0] in_addr,
  output logic          s1_valid,
  output logic          out_valid,
  output logic [7:0]    out_gray,
  output logic [AW-1:0] out_addr
);

  localparam int STAGES = 2;

  logic [STAGES-1:0] vld_pipe;
  logic [15:0]       p_r, p_g, p_b;
  logic [AW-1:0]     addr1;
  logic [15:0]       sum;

  // Worst case 255,255,255 sums to 65408, so 16 bits never overflow.
  assign sum = p_r + p_g + p_b + RND;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      p_r      <= '0;
      p_g      <= '0;
      p_b      <= '0;
      addr1    <= '0;
      out_gray <= '0;
      out_addr <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], in_valid};
      if (in_valid) begin
        p_r   <= 16'(in_pix.r) * C_R;
        p_g   <= 16'(in_pix.g) * C_G;
        p_b   <= 16'(in_pix.b) * C_B;
        addr1 <= in_addr;
      end
      if (vld_pipe[0]) begin
        out_gray <= sum[15:8];
        out_addr <= addr1;
      end
    end
  end

  assign s1_valid  = vld_pipe[0];
  assign out_valid = vld_pipe[STAGES-1];

endmodule

// File: rtl/rgb2gray_frame_loader.sv
// Loads one raster RGB frame into the gray SRAM, then lends the SRAM read
// port to the LBP engine until it signals finish.
module rgb2gray_frame_loader
  import gray_pkg::*;
#(
  parameter int IMG_W = IMG_W_D,
  parameter int IMG_H = IMG_H_D,
  parameter int AW    = AW_D
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_valid,
  output logic          pix_ready,
  input  logic          pix_sof,
  input  logic [7:0]    pix_r,
  input  logic [7:0]    pix_g,
  input  logic [7:0]    pix_b,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wen,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic          gray_ready,
  input  logic          gray_req,
  input  logic [AW-1:0] gray_addr,
  output logic [7:0]    gray_data,
  input  logic          lbp_finish,
  output logic          frame_err
);

  localparam logic [AW-1:0] LAST = AW'(IMG_W * IMG_H - 1);

  state_t        state;
  logic [AW-1:0] cnt;
  logic          accept, pipe_in_vld, s1_vld, wr_vld;
  logic [AW-1:0] in_addr, wr_addr;
  logic [7:0]    wr_gray;
  rgb_t          pix;

  assign accept      = pix_valid & pix_ready;
  // In IDLE only an sof pixel enters the pipe; stray pixels are dropped.
  assign pipe_in_vld = accept & (pix_sof | (state == FILL));
  assign in_addr     = pix_sof ? '0 : cnt;
  assign pix         = {pix_r, pix_g, pix_b};

  rgb2gray_pipe #(.AW(AW)) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (pipe_in_vld),
    .in_pix    (pix),
    .in_addr   (in_addr),
    .s1_valid  (s1_vld),
    .out_valid (wr_vld),
    .out_gray  (wr_gray),
    .out_addr  (wr_addr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      pix_ready  <= 1'b0;
      gray_ready <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          pix_ready <= 1'b1;
          if (accept && pix_sof) begin
            cnt   <= AW'(1);
            state <= FILL;
          end
        end
        FILL: begin
          if (accept) begin
            if (pix_sof) begin
              frame_err <= 1'b1;
              cnt       <= AW'(1);
            end else if (cnt == LAST) begin
              cnt       <= '0;
              pix_ready <= 1'b0;
              state     <= DRAIN;
            end else begin
              cnt <= cnt + AW'(1);
            end
          end
        end
        // Once stage 1 is empty the final write is on the SRAM port now.
        DRAIN: begin
          if (!s1_vld) begin
            gray_ready <= 1'b1;
            state      <= READY;
          end
        end
        READY: begin
          if (lbp_finish) begin
            gray_ready <= 1'b0;
            pix_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_wen   = wr_vld & (state != READY);
  assign mem_wdata = wr_gray;
  assign mem_addr  = (state == READY) ? gray_addr : wr_addr;
  assign gray_data = ((state == READY) && gray_req) ? mem_rdata : 8'd0;

endmodule

// File: tb/tb_rgb2gray_frame_loader.sv
// Randomized scoreboard bench for rgb2gray_frame_loader with a frame-level
// reference model and a behavioural SRAM.
module tb_rgb2gray_frame_loader;

  localparam int IMG_W = 128;
  localparam int IMG_H = 128;
  localparam int AW    = 14;
  localparam int NPIX  = IMG_W * IMG_H;

  logic          clk = 1'b0;
  logic          reset;
  logic          pix_valid, pix_ready, pix_sof;
  logic [7:0]    pix_r, pix_g, pix_b;
  logic [AW-1:0] mem_addr;
  logic          mem_wen;
  logic [7:0]    mem_wdata, mem_rdata;
  logic          gray_ready, gray_req;
  logic [AW-1:0] gray_addr;
  logic [7:0]    gray_data;
  logic          lbp_finish, frame_err;

  rgb2gray_frame_loader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_sof    (pix_sof),
    .pix_r      (pix_r),
    .pix_g      (pix_g),
    .pix_b      (pix_b),
    .mem_addr   (mem_addr),
    .mem_wen    (mem_wen),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .gray_ready (gray_ready),
    .gray_req   (gray_req),
    .gray_addr  (gray_addr),
    .gray_data  (gray_data),
    .lbp_finish (lbp_finish),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  logic [7:0] sram [0:NPIX-1];
  always @(posedge clk) if (mem_wen) sram[mem_addr] <= mem_wdata;
  assign mem_rdata = sram[mem_addr];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int gray_of(input int r, input int g, input int b);
    return (77 * r + 150 * g + 29 * b + 128) / 256;
  endfunction

  // ---------------- reference model + monitor ----------------
  typedef struct {
    int addr;
    int data;
    int due;
  } wr_t;

  wr_t q[$];
  int  ref_img [0:NPIX-1];
  int  cyc = 0;
  int  idx = 0;
  int  last_due = -1;
  bit  in_frame = 0, busy = 0, gr_exp = 0, err_exp = 0, pr_exp = 0;

  always @(negedge clk) begin
    wr_t w;
    int  g;
    bit  acc;
    cyc++;
    if (reset) begin
      chk("rst_mem_wen", mem_wen, 0);
      chk("rst_pix_ready", pix_ready, 0);
      chk("rst_gray_ready", gray_ready, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_gray_data", gray_data, 0);
      q.delete();
      in_frame = 0; busy = 0; gr_exp = 0; err_exp = 0; pr_exp = 0; last_due = -1;
    end else begin
      chk("pix_ready", pix_ready, pr_exp);
      chk("gray_ready", gray_ready, gr_exp);
      chk("frame_err", frame_err, err_exp);
      if (mem_wen) begin
        if (q.size() == 0) chk("spurious_write", 1, 0);
        else begin
          w = q.pop_front();
          chk("wr_addr", mem_addr, w.addr);
          chk("wr_data", mem_wdata, w.data);
          chk("wr_latency", cyc, w.due);
        end
      end else if (q.size() != 0 && q[0].due <= cyc) begin
        chk("missing_write", 0, 1);
        void'(q.pop_front());
      end
      if (gr_exp && gray_req) begin
        chk("rd_mem_addr", mem_addr, gray_addr);
        chk("rd_gray_data", gray_data, ref_img[gray_addr]);
      end else begin
        chk("gray_data_zero", gray_data, 0);
      end

      // advance the model with the inputs the next edge will see
      err_exp = 0;
      acc = pix_valid && pix_ready;
      if (acc && pix_sof) begin
        err_exp  = in_frame;
        in_frame = 1;
        idx      = 0;
      end
      if (acc && in_frame) begin
        g = gray_of(pix_r, pix_g, pix_b);
        ref_img[idx] = g;
        q.push_back('{idx, g, cyc + 2});
        idx++;
        if (idx == NPIX) begin
          in_frame = 0;
          busy     = 1;
          last_due = cyc + 2;
        end
      end
      if (gr_exp && lbp_finish) begin
        gr_exp = 0;
        busy   = 0;
      end else if (busy && cyc == last_due) begin
        gr_exp = 1;
      end
      pr_exp = !busy;
    end
  end

  // ---------------- stimulus ----------------
  task automatic put(input bit sof, input logic [7:0] r, input logic [7:0] g,
                     input logic [7:0] b);
    int guard;
    @(posedge clk); #1;
    pix_valid  = 1'b0;
    lbp_finish = 1'b0;
    if ($urandom_range(0, 15) == 0) begin @(posedge clk); #1; end
    guard = 0;
    while (!pix_ready && guard < 40) begin @(posedge clk); #1; guard++; end
    if (!pix_ready) chk("pix_ready_timeout", 0, 1);
    pix_valid  = 1'b1;
    pix_sof    = sof;
    pix_r      = r;
    pix_g      = g;
    pix_b      = b;
    lbp_finish = ($urandom_range(0, 63) == 0);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    pix_valid  = 1'b0;
    pix_sof    = 1'b0;
    lbp_finish = 1'b0;
  endtask

  task automatic read_phase();
    int guard = 0;
    while (!gray_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    chk("gray_ready_timeout", gray_ready, 1);
    @(posedge clk); #1;
    gray_req  = 1'b1;
    gray_addr = {7'd2, 7'd3};
    repeat (4) begin
      @(posedge clk); #1;
      gray_addr = AW'($urandom_range(0, NPIX - 1));
    end
    @(posedge clk); #1;
    gray_req = 1'b0;
    @(posedge clk); #1;
    lbp_finish = 1'b1;
    @(posedge clk); #1;
    lbp_finish = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [7:0] cr [5] = '{8'd255, 8'd0,   8'd0,   8'd255, 8'd0};
  logic [7:0] cg [5] = '{8'd0,   8'd255, 8'd0,   8'd255, 8'd0};
  logic [7:0] cb [5] = '{8'd0,   8'd0,   8'd255, 8'd255, 8'd0};

  initial begin
    reset = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0;
    pix_r = '0; pix_g = '0; pix_b = '0;
    gray_req = 1'b0; gray_addr = '0; lbp_finish = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // flat gray frame
    for (int i = 0; i < NPIX; i++) put(i == 0, 8'd100, 8'd100, 8'd100);
    idle();
    read_phase();

    // stray pixels in IDLE are dropped
    for (int i = 0; i < 5; i++)
      put(1'b0, 8'($urandom), 8'($urandom), 8'($urandom));

    // corner colours, then an sof restart at index 500 and a full frame
    for (int i = 0; i < 500; i++) begin
      if (i < 5) put(i == 0, cr[i], cg[i], cb[i]);
      else       put(i == 0, 8'($urandom), 8'($urandom), 8'($urandom));
    end
    for (int i = 0; i < NPIX; i++)
      put(i == 0, 8'($urandom), 8'($urandom), 8'($urandom));
    idle();
    read_phase();

    // reset in the middle of a frame, then restart
    for (int i = 0; i < 8000; i++)
      put(i == 0, 8'($urandom), 8'($urandom), 8'($urandom));
    @(posedge clk); #1;
    reset = 1'b1; pix_valid = 1'b0; lbp_finish = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 20; i++)
      put(i == 0, 8'($urandom), 8'($urandom), 8'($urandom));
    idle();
    repeat (6) @(posedge clk);
    #1;
    chk("scoreboard_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
